// File: rtl/tt_um_muaz_byte_link.sv
// Byte link responder: host pushes bytes in and pulls them out over two 4-phase REQ/ACK handshakes, with an internal FIFO between them.
// Latency: REQ pin edge to ACK edge is SYNC_STAGES+1 clocks. A read presents the byte on uo_out no later than RD_ACK rises.
// Backpressure: a write to a full FIFO is ACKed, dropped, and sets sticky OVF. A read of an empty FIFO is ACKed and sets sticky UNF.
// Optional build macro TT_LINK_CHECKSUM_EN: every accepted byte is XORed into a checksum, and an empty read returns that checksum.

module tt_um_muaz_byte_link #(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic { W_IDLE = 1'b0, W_ACK = 1'b1 } w_state_e;
    typedef enum logic { R_IDLE = 1'b0, R_ACK = 1'b1 } r_state_e;

    // ------------------------------------------------------------------
    // Request synchronizers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] wr_sync_q;
    logic [SYNC_STAGES-1:0] rd_sync_q;
    logic                   wr_req_s;
    logic                   rd_req_s;

    // Shift both host requests into the core clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sync_q <= '0;
            rd_sync_q <= '0;
        end else begin
            wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], uio_in[0]};
            rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], uio_in[2]};
        end
    end

    assign wr_req_s = wr_sync_q[SYNC_STAGES-1];
    assign rd_req_s = rd_sync_q[SYNC_STAGES-1];

    // Only WR_REQ and RD_REQ are used. The other bidirectional pins are outputs or unused.
    logic unused_ok;
    assign unused_ok = &{1'b0, uio_in[7:3], uio_in[1]};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    w_state_e        w_state_q, w_state_d;
    r_state_e        r_state_q, r_state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [7:0]      uo_q, uo_d;
    logic            presented_q, presented_d;
    logic            full_q, empty_q;
    logic            ovf_q, unf_q;
    logic            push, pop, ovf_set, unf_set;
    logic [7:0]      empty_val;

`ifdef TT_LINK_CHECKSUM_EN
    logic [7:0]      chk_q, chk_d;

    // Running XOR of every accepted byte.
    always_comb begin
        chk_d = chk_q;
        if (push) begin
            chk_d = chk_q ^ ui_in;
        end
    end

    // Hold the checksum register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q <= 8'h00;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign empty_val = chk_q;
`else
    assign empty_val = 8'h00;
`endif

    // Write handshake FSM.
    // The full check uses count_q, which is the count before any pop in the same cycle.
    always_comb begin
        w_state_d = w_state_q;
        push      = 1'b0;
        ovf_set   = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (wr_req_s && ena) begin
                    w_state_d = W_ACK;
                    if (count_q < DEPTH_C) begin
                        push = 1'b1;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
            end
            W_ACK: begin
                // The handshake completes even if ena has dropped.
                if (!wr_req_s) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read handshake FSM.
    // The head byte is latched on entry to R_ACK and popped on exit, but only if a real byte was presented.
    always_comb begin
        r_state_d   = r_state_q;
        presented_d = presented_q;
        uo_d        = uo_q;
        pop         = 1'b0;
        unf_set     = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (rd_req_s && ena) begin
                    r_state_d = R_ACK;
                    if (count_q != '0) begin
                        uo_d        = mem_q[rd_ptr_q];
                        presented_d = 1'b1;
                    end else begin
                        uo_d        = empty_val;
                        presented_d = 1'b0;
                        unf_set     = 1'b1;
                    end
                end
            end
            R_ACK: begin
                if (!rd_req_s) begin
                    r_state_d   = R_IDLE;
                    pop         = presented_q;
                    presented_d = 1'b0;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Pointer and occupancy bookkeeping.
    // When a push and a pop happen in the same cycle, the count is unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            uo_q        <= 8'h00;
            presented_q <= 1'b0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            uo_q        <= uo_d;
            presented_q <= presented_d;
            full_q      <= (count_d == DEPTH_C);
            empty_q     <= (count_d == '0);
            ovf_q       <= ovf_q | ovf_set;
            unf_q       <= unf_q | unf_set;
        end
    end

    // FIFO storage. It has no reset because the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ui_in;
        end
    end

    assign uo_out  = uo_q;
    assign uio_out = {unf_q, ovf_q, empty_q, full_q,
                      (r_state_q == R_ACK), 1'b0, (w_state_q == W_ACK), 1'b0};
    assign uio_oe  = 8'b1111_1010;

endmodule

// File: tb/tb_tt_um_muaz_byte_link.sv
// Directed bench for tt_um_muaz_byte_link with hand-computed expected values.
// Inputs are driven 1 ns after the rising clock edge, and outputs are sampled there.
// Every wait on an ACK edge is bounded, and a timeout shows up as a failed comparison.

module tb_tt_um_muaz_byte_link;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       wr_req;
    logic       rd_req;

    int n_tests;
    int n_fail;

    assign uio_in = {5'b0, rd_req, 1'b0, wr_req};

    tt_um_muaz_byte_link #(.DEPTH(8), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic ack_bit(input int sel);
        return (sel == 0) ? uio_out[1] : uio_out[3];
    endfunction

    // Step one clock at a time until the selected ACK reaches lvl or max clocks pass.
    task automatic wait_ack(input int sel, input logic lvl, input int max, output int n);
        n = 0;
        while (ack_bit(sel) !== lvl && n < max) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic do_write(input logic [7:0] b, output int lat);
        int n;
        ui_in  = b;
        wr_req = 1'b1;
        wait_ack(0, 1'b1, 20, lat);
        check("wr_ack_rise", {31'd0, uio_out[1]}, 32'd1);
        wr_req = 1'b0;
        wait_ack(0, 1'b0, 20, n);
        check("wr_ack_fall", {31'd0, uio_out[1]}, 32'd0);
    endtask

    task automatic do_read(output logic [7:0] d, output int lat);
        int n;
        rd_req = 1'b1;
        wait_ack(1, 1'b1, 20, lat);
        check("rd_ack_rise", {31'd0, uio_out[3]}, 32'd1);
        d      = uo_out;
        rd_req = 1'b0;
        wait_ack(1, 1'b0, 20, n);
        check("rd_ack_fall", {31'd0, uio_out[3]}, 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        int         lat;
        int         n;
        logic [7:0] exp_empty;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        ena     = 1'b1;
        ui_in   = 8'h00;
        wr_req  = 1'b0;
        rd_req  = 1'b0;

        // Check the state while reset is held.
        repeat (3) @(posedge clk);
        #1;
        check("rst_uo_out",  {24'd0, uo_out},  32'h00);
        check("rst_uio_out", {24'd0, uio_out}, 32'h20);
        check("rst_uio_oe",  {24'd0, uio_oe},  32'hFA);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic write/read, including handshake latency.
        do_write(8'hA5, lat);
        check("wr_latency", lat, 32'd3);
        check("not_empty", {31'd0, uio_out[5]}, 32'd0);
        do_write(8'h3C, lat);
        do_read(d, lat);
        check("rd_latency", lat, 32'd3);
        check("rd0", {24'd0, d}, 32'hA5);
        do_read(d, lat);
        check("rd1", {24'd0, d}, 32'h3C);
        check("empty_after_drain", {31'd0, uio_out[5]}, 32'd1);
        check("no_unf_yet", {31'd0, uio_out[7]}, 32'd0);

        // Read on an empty FIFO.
`ifdef TT_LINK_CHECKSUM_EN
        exp_empty = 8'h99;
`else
        exp_empty = 8'h00;
`endif
        do_read(d, lat);
        check("empty_read_val", {24'd0, d}, {24'd0, exp_empty});
        check("unf_set", {31'd0, uio_out[7]}, 32'd1);

        // Overflow case.
        for (int i = 1; i <= 8; i++) begin
            do_write(8'(i), lat);
        end
        check("full_after_8", {31'd0, uio_out[4]}, 32'd1);
        check("no_ovf_yet", {31'd0, uio_out[6]}, 32'd0);
        do_write(8'h09, lat);
        check("ovf_set", {31'd0, uio_out[6]}, 32'd1);
        for (int i = 1; i <= 8; i++) begin
            do_read(d, lat);
            check("ovf_drain", {24'd0, d}, i);
        end
        check("ovf_sticky", {31'd0, uio_out[6]}, 32'd1);
        check("empty_after_ovf", {31'd0, uio_out[5]}, 32'd1);

        // Same-cycle push and pop with 7 entries, then a drain across the pointer wrap.
        for (int i = 0; i < 7; i++) begin
            do_write(8'h10 + 8'(i), lat);
        end
        rd_req = 1'b1;
        wait_ack(1, 1'b1, 20, n);
        check("ovl_rd_ack", {31'd0, uio_out[3]}, 32'd1);
        check("ovl_head", {24'd0, uo_out}, 32'h10);
        rd_req = 1'b0;
        ui_in  = 8'h17;
        wr_req = 1'b1;
        wait_ack(0, 1'b1, 20, n);
        check("ovl_wr_ack", {31'd0, uio_out[1]}, 32'd1);
        check("ovl_rd_done", {31'd0, uio_out[3]}, 32'd0);
        check("ovl_not_full", {31'd0, uio_out[4]}, 32'd0);
        wr_req = 1'b0;
        wait_ack(0, 1'b0, 20, n);
        do_write(8'h18, lat);
        check("ovl_full_at_8", {31'd0, uio_out[4]}, 32'd1);
        for (int i = 1; i <= 8; i++) begin
            do_read(d, lat);
            check("wrap_drain", {24'd0, d}, 32'h10 + i);
        end
        check("wrap_empty", {31'd0, uio_out[5]}, 32'd1);

        // ena gating, then reset in the middle of a handshake.
        ena    = 1'b0;
        ui_in  = 8'h55;
        wr_req = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (uio_out[1]) n++;
        end
        check("ena_low_no_ack", n, 32'd0);
        ena = 1'b1;
        wait_ack(0, 1'b1, 3, n);
        check("ena_high_ack", {31'd0, uio_out[1]}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ack", {31'd0, uio_out[1]}, 32'd0);
        check("rst_mid_flags", {24'd0, uio_out}, 32'h20);
        wr_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_read(d, lat);
        check("post_rst_empty_read", {24'd0, d}, 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tt_um_muaz_byte_link.md
Name: tt_um_muaz_byte_link

Overview:
- Tiny Tapeout user project: the responder for a host (cocotb bench or external MCU) that drives the standard tt_um pin set.
- Host pushes bytes in over ui_in using a 4-phase REQ/ACK handshake on uio, and pulls them back out on uo_out using a second 4-phase handshake.
- Bytes are buffered in an internal FIFO; status flags are on uio_out.

Parameters:
- DEPTH, 8, FIFO depth in bytes; power of 2, minimum 2.
- SYNC_STAGES, 2, flops in each REQ input synchronizer; minimum 2.

Ports:
- clk  input  1  project clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  design selected; while low, new handshakes are not started
- ui_in  input  8  write data from host; must be stable while WR_REQ is high
- uo_out  output  8  read data to host; registered
- uio_in  input  8  [0] WR_REQ, [2] RD_REQ; other bits ignored
- uio_out  output  8  [1] WR_ACK, [3] RD_ACK, [4] FULL, [5] EMPTY, [6] OVF sticky, [7] UNF sticky, [0],[2]=0
- uio_oe  output  8  constant 8'b1111_1010

Behaviour:
- Reset (async assert, sync release): uo_out=0x00, WR_ACK=0, RD_ACK=0, FULL=0, EMPTY=1, OVF=0, UNF=0; FIFO pointers and count=0; both FSMs IDLE.
- Resetting mid-handshake aborts it. Host must drop REQ before starting again.
- WR_REQ and RD_REQ each pass through a SYNC_STAGES synchronizer; edge detection uses the synchronized value.
- Write FSM states W_IDLE, W_ACK:
  - W_IDLE -> W_ACK on synchronized WR_REQ high with ena=1.
  - On that transition: if count<DEPTH, push ui_in (sampled that cycle); else drop the byte and set OVF.
  - WR_ACK=1 registered in W_ACK.
  - W_ACK -> W_IDLE when synchronized WR_REQ is low; WR_ACK falls the same edge.
- Read FSM states R_IDLE, R_ACK:
  - R_IDLE -> R_ACK on synchronized RD_REQ high with ena=1.
  - On that transition: uo_out <= FIFO head if count>0; else uo_out <= empty-value (see Optional Feature) and set UNF.
  - RD_ACK=1 in R_ACK. uo_out is valid no later than RD_ACK rising.
  - R_ACK -> R_IDLE when synchronized RD_REQ is low. Pop on this exit only if a byte was presented.
  - uo_out holds its value until the next read.
- Latency: pin REQ rise to ACK rise = SYNC_STAGES+1 cycles; same for REQ fall to ACK fall.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Push and pop in the same cycle: both execute, count unchanged. The full check uses the count before the pop, so a write to a full FIFO is dropped even if a pop occurs that cycle.
- FULL = (count==DEPTH); EMPTY = (count==0); both registered, updated the cycle after push/pop.
- OVF/UNF clear only on reset.
- ena low:
  - An FSM in IDLE stays there.
  - An FSM already in an ACK state still completes its handshake.
  - FIFO contents are retained.

Optional Feature:
- Macro TT_LINK_CHECKSUM_EN.
- Defined:
  - An 8-bit register chk (reset 0x00) is updated as chk <= chk ^ byte on every accepted push.
  - A read on an empty FIFO returns chk on uo_out and still sets UNF.
- Not defined: no chk register; a read on an empty FIFO returns 0x00.

Test Plan:
- Reset with all inputs 0 -> uo_out=0x00, uio_out=8'b0010_0000, uio_oe=8'hFA.
- Write 0xA5 then 0x3C; read twice -> uo_out=0xA5 then 0x3C. WR_ACK rises 3 cycles after WR_REQ (SYNC_STAGES=2). EMPTY=1 after the second read.
- Write 9 bytes 0x01..0x09 -> FULL=1 after the 8th; 9th is ACKed, dropped, OVF=1. Reading 8 returns 0x01..0x08; OVF stays 1.
- Read on empty -> RD_ACK toggles, UNF=1, uo_out=0x00. With TT_LINK_CHECKSUM_EN, after writing 0xA5 and 0x3C and draining, uo_out=0x99.
- Fill to 7, then overlap a read pop with a write push in the same cycle -> count stays 7, FULL=0. Drained order is preserved across pointer wrap.
- Hold ena=0 and raise WR_REQ -> no ACK for 20 cycles. Set ena=1 -> ACK follows within 3 cycles. Assert rst_n=0 during W_ACK -> WR_ACK drops immediately and the FIFO is empty.
